// File: rtl/ppm_final_adder_if.sv
// Row-pair in / product out stream bundle for the multiplier final adder.
// The slave side is the adder; the master side is whoever feeds the rows
// and consumes the product.
interface ppm_final_adder_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_sum;
  logic [W-1:0] in_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_product;
  logic         out_cout;

  modport slave (
    input  in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_product, out_cout
  );

  modport master (
    output in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_product, out_cout
  );
endinterface

// File: rtl/ppm_final_adder.sv
// Final carry-propagate adder of the 16-bit approximate multiplier.
// Two-stage split adder: stage 1 adds bits [SPLIT-1:0], stage 2 adds the
// high slices with the registered low carry. Valid/ready on both sides,
// two-entry skid-free pipeline (s1, s2) that holds under backpressure.
//
// Build option: define PPM_APPROX_LOW_EN to replace the lowest APPROX_BITS
// bits with a carry-free OR and a predicted carry (s[A-1] & c[A-1]).
// Without it the whole add is exact.
module ppm_final_adder #(
  parameter int W           = 32,
  parameter int SPLIT       = 16,
  parameter int APPROX_BITS = 8
) (
  input logic             clk,
  input logic             rst,
  ppm_final_adder_if.slave bus
);
  localparam int HW = W - SPLIT;

  typedef struct packed {
    logic [HW-1:0]    hi_sum;
    logic [HW-1:0]    hi_carry;
    logic             lo_cout;
    logic [SPLIT-1:0] lo_sum;
  } s1_t;

  typedef struct packed {
    logic         cout;
    logic [W-1:0] product;
  } s2_t;

  logic s1_valid, s2_valid;
  logic s1_load, s2_load;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;

  // ---------------------------------------------------------------------
  // Stage 1 low add, split at APPROX_BITS so both builds share the upper
  // part of the low region; only the bottom slice differs.
  // ---------------------------------------------------------------------
  logic [APPROX_BITS-1:0] a_sum;
  logic                   a_cout;
  logic [SPLIT-1:0]       lo_sum;
  logic                   lo_cout;

`ifdef PPM_APPROX_LOW_EN
  // bottom slice: no carry chain, carry predicted from the top bit only
  assign a_sum  = bus.in_sum[APPROX_BITS-1:0] | bus.in_carry[APPROX_BITS-1:0];
  assign a_cout = bus.in_sum[APPROX_BITS-1] & bus.in_carry[APPROX_BITS-1];
`else
  // bottom slice: exact add, carry chained into the rest of the low region
  assign {a_cout, a_sum} = {1'b0, bus.in_sum[APPROX_BITS-1:0]}
                         + {1'b0, bus.in_carry[APPROX_BITS-1:0]};
`endif

  generate
    if (APPROX_BITS < SPLIT) begin : g_mid
      localparam int MW = SPLIT - APPROX_BITS;
      logic [MW:0] m_full;
      assign m_full  = {1'b0, bus.in_sum[SPLIT-1:APPROX_BITS]}
                     + {1'b0, bus.in_carry[SPLIT-1:APPROX_BITS]}
                     + {{MW{1'b0}}, a_cout};
      assign lo_sum  = {m_full[MW-1:0], a_sum};
      assign lo_cout = m_full[MW];
    end else begin : g_nomid
      // low region is entirely the bottom slice
      assign lo_sum  = a_sum;
      assign lo_cout = a_cout;
    end
  endgenerate

  // stage 1 payload: low result plus untouched high slices
  always_comb begin
    s1_d          = '0;
    s1_d.lo_sum   = lo_sum;
    s1_d.lo_cout  = lo_cout;
    s1_d.hi_sum   = bus.in_sum[W-1:SPLIT];
    s1_d.hi_carry = bus.in_carry[W-1:SPLIT];
  end

  // ---------------------------------------------------------------------
  // Stage 2 high add with the registered low carry.
  // ---------------------------------------------------------------------
  logic [HW:0] hi_full;
  assign hi_full = {1'b0, s1_q.hi_sum} + {1'b0, s1_q.hi_carry}
                 + {{HW{1'b0}}, s1_q.lo_cout};

  // stage 2 payload: assembled product and carry out of bit W-1
  always_comb begin
    s2_d         = '0;
    s2_d.product = {hi_full[HW-1:0], s1_q.lo_sum};
    s2_d.cout    = hi_full[HW];
  end

  // ---------------------------------------------------------------------
  // Handshake. in_ready sees out_ready combinationally through s2_load so
  // a full pipe can still take a new pair in the cycle s2 drains.
  // ---------------------------------------------------------------------
  assign s2_load      = s1_valid & (~s2_valid | bus.out_ready);
  assign bus.in_ready = ~s1_valid | s2_load;
  assign s1_load      = bus.in_valid & bus.in_ready;

  // pipeline state: valid bits advance every cycle, payloads only on load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      s1_valid <= s1_load | (s1_valid & ~s2_load);
      s2_valid <= s2_load | (s2_valid & ~bus.out_ready);
      if (s1_load) s1_q <= s1_d;
      if (s2_load) s2_q <= s2_d;
    end
  end

  assign bus.out_valid   = s2_valid;
  assign bus.out_product = s2_q.product;
  assign bus.out_cout    = s2_q.cout;

endmodule
